// File: rtl/sprite_line_engine_m.sv
// Scanline-buffered foreground sprite engine: evaluates object memory during hblank,
// latches up to MAX_PER_LINE sprite rows into slots, then composites from the slots only.
module sprite_line_engine_m #(
  parameter int NUM_OBJECTS     = 64,
  parameter int MAX_PER_LINE    = 8,
  parameter int VRAM_ADDR_WIDTH = 12
) (
  input  logic                       clk_12_5875,
  input  logic                       rst,
  input  logic [7:0]                 current_x,
  input  logic                       line_start,
  input  logic [7:0]                 next_y,
  input  logic                       writable,
  input  logic [7:0]                 data_in,
  input  logic [VRAM_ADDR_WIDTH-1:0] address,
  input  logic                       write_enable,
  output logic [1:0]                 r,
  output logic [1:0]                 g,
  output logic [1:0]                 b,
  output logic                       valid,
  output logic                       overflow,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int OIW = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS) : 1;
  localparam int SW  = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int CW  = $clog2(MAX_PER_LINE + 1);
  localparam logic [VRAM_ADDR_WIDTH-9:0] OBM_PAGE = (VRAM_ADDR_WIDTH-8)'(8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t state, state_nx;

  // ------------------------------------------------------------------
  // VRAM: pattern memory and object memory, written only while idle
  // ------------------------------------------------------------------
  logic [7:0] pmf [0:511];
  logic [7:0] obm [0:255];
  logic       pmf_sel, obm_sel, vram_we;

  assign pmf_sel = (address[VRAM_ADDR_WIDTH-1:9] == '0);
  assign obm_sel = (address[VRAM_ADDR_WIDTH-1:8] == OBM_PAGE);
  assign vram_we = write_enable && writable && (state == IDLE);

  always_ff @(posedge clk_12_5875) begin
    if (vram_we && pmf_sel) pmf[address[8:0]] <= data_in;
    if (vram_we && obm_sel) obm[address[7:0]] <= data_in;
  end

  // ------------------------------------------------------------------
  // Line evaluation / fetch bookkeeping
  // ------------------------------------------------------------------
  logic [7:0]              eval_y;
  logic [OIW-1:0]          eval_idx;
  logic [CW-1:0]           hit_cnt;
  logic [SW-1:0]           fetch_slot;

  logic [OIW-1:0]          slot_obj   [MAX_PER_LINE];
  logic [15:0]             slot_row   [MAX_PER_LINE];
  logic [7:0]              slot_x     [MAX_PER_LINE];
  logic [2:0]              slot_color [MAX_PER_LINE];
  logic [MAX_PER_LINE-1:0] slot_hflip;
  logic [MAX_PER_LINE-1:0] slot_valid;

  // EVAL: hit test of the object under eval_idx (9-bit compare, no wrap)
  logic [7:0] e_base, e_oy;
  logic       e_hit, e_last, slots_full;

  always_comb begin
    e_base     = 8'({eval_idx, 2'b00});
    e_oy       = obm[e_base | 8'd1];
    e_hit      = ({1'b0, eval_y} >= {1'b0, e_oy}) &&
                 ({1'b0, eval_y} <  ({1'b0, e_oy} + 9'd8));
    e_last     = (eval_idx == OIW'(NUM_OBJECTS - 1));
    slots_full = (hit_cnt == CW'(MAX_PER_LINE));
  end

  // FETCH: row address of the object recorded in fetch_slot
  logic [OIW-1:0] f_obj;
  logic [7:0]     f_base, f_oy;
  logic [2:0]     f_row0, f_row;
  logic [8:0]     f_addr;
  logic [15:0]    f_data;
  logic           f_last;

  always_comb begin
    f_obj  = slot_obj[fetch_slot];
    f_base = 8'({f_obj, 2'b00});
    f_oy   = obm[f_base | 8'd1];
    f_row0 = 3'(eval_y - f_oy);
    f_row  = obm[f_base | 8'd2][5] ? ~f_row0 : f_row0;
    f_addr = {obm[f_base | 8'd2][4:0], f_row, 1'b0};
    f_data = {pmf[f_addr], pmf[f_addr | 9'd1]};
    f_last = ((CW'(fetch_slot) + CW'(1)) == hit_cnt);
  end

  // ------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (line_start) begin
      state_nx = EVAL;
    end else begin
      case (state)
        EVAL: begin
          if (e_hit && slots_full)
            state_nx = FETCH;
          else if (e_last)
            state_nx = ((hit_cnt != '0) || e_hit) ? FETCH : IDLE;
        end
        FETCH: begin
          if (f_last) state_nx = IDLE;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // ------------------------------------------------------------------
  // Slot datapath; line_start always wins and discards partial work
  // ------------------------------------------------------------------
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      eval_y     <= '0;
      eval_idx   <= '0;
      hit_cnt    <= '0;
      fetch_slot <= '0;
      overflow   <= 1'b0;
      slot_valid <= '0;
      slot_hflip <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        slot_obj[i]   <= '0;
        slot_row[i]   <= '0;
        slot_x[i]     <= '0;
        slot_color[i] <= '0;
      end
    end else if (line_start) begin
      eval_y     <= next_y;
      eval_idx   <= '0;
      hit_cnt    <= '0;
      fetch_slot <= '0;
      overflow   <= 1'b0;
      slot_valid <= '0;
    end else if (state == EVAL) begin
      eval_idx <= eval_idx + OIW'(1);
      if (e_hit) begin
        if (slots_full) begin
          overflow <= 1'b1;
        end else begin
          slot_obj[hit_cnt[SW-1:0]] <= eval_idx;
          hit_cnt                   <= hit_cnt + CW'(1);
        end
      end
    end else if (state == FETCH) begin
      slot_row[fetch_slot]   <= f_data;
      slot_x[fetch_slot]     <= obm[f_base];
      slot_hflip[fetch_slot] <= obm[f_base | 8'd2][6];
      slot_color[fetch_slot] <= obm[f_base | 8'd3][2:0];
      slot_valid[fetch_slot] <= 1'b1;
      fetch_slot             <= fetch_slot + SW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Compositing: descending scan so the lowest opaque covering slot wins
  // ------------------------------------------------------------------
  logic [2:0] c_px, c_pidx;
  logic [1:0] c_pix, win_pix;
  logic [2:0] win_col;
  logic       c_cov;

  always_comb begin
    c_px    = '0;
    c_pidx  = '0;
    c_pix   = '0;
    c_cov   = 1'b0;
    win_pix = '0;
    win_col = '0;
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      c_cov  = slot_valid[s] &&
               ({1'b0, current_x} >= {1'b0, slot_x[s]}) &&
               ({1'b0, current_x} <  ({1'b0, slot_x[s]} + 9'd8));
      c_px   = 3'(current_x - slot_x[s]);
      c_pidx = slot_hflip[s] ? c_px : ~c_px;
      c_pix  = slot_row[s][{c_pidx, 1'b0} +: 2];
      if (c_cov && (c_pix != 2'b00)) begin
        win_pix = c_pix;
        win_col = slot_color[s];
      end
    end
  end

  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      valid <= 1'b0;
    end else if ((state == IDLE) && (win_pix != 2'b00)) begin
      r     <= win_pix & {2{win_col[2]}};
      g     <= win_pix & {2{win_col[1]}};
      b     <= win_pix & {2{win_col[0]}};
      valid <= 1'b1;
    end else begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      valid <= 1'b0;
    end
  end

endmodule

// File: doc/sprite_line_engine_m.md
# sprite_line_engine_m

Scanline-buffered foreground sprite engine. It generalises the per-pixel all-objects foreground: instead of comparing every object against every pixel, it evaluates object memory once per line during horizontal blanking and latches up to `MAX_PER_LINE` visible sprite rows into slot registers. During the active line it composites pixels from those slots only, and it flags lines that carry more sprites than it has slots. It sits in the GPU beside background/text layers and feeds the layer mixer with `r/g/b/valid`.

## Interface
- `NUM_OBJECTS`, 64: OBM entries scanned per line (1..64).
- `MAX_PER_LINE`, 8: sprite slots per line (1..NUM_OBJECTS).
- `VRAM_ADDR_WIDTH`, 12: VRAM address width.
- `clk_12_5875` in 1: pixel clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `current_x` in 8: pixel being displayed.
- `line_start` in 1: one-cycle pulse at start of hblank preceding line `next_y`.
- `next_y` in 8: line to evaluate; sampled when `line_start`=1.
- `writable` in 1: VRAM write window from video timing.
- `data_in` in 8: VRAM write data.
- `address` in `VRAM_ADDR_WIDTH`: VRAM write address.
- `write_enable` in 1: write strobe.
- `r`, `g`, `b` out 2 each: pixel colour.
- `valid` out 1: opaque sprite pixel present.
- `overflow` out 1: the evaluated line had more than `MAX_PER_LINE` hits.
- `busy` out 1: evaluation/fetch in progress.

## Operation
- Memories:
  - PMF is 512 B at 0x000–0x1FF; pattern p, row y = bytes {p,y,0},{p,y,1}, first byte high.
  - OBM is 256 B at 0x800–0x8FF; object n bytes:
    - 4n = x
    - 4n+1 = y
    - 4n+2 = {-, hflip[6], vflip[5], pmfa[4:0]}
    - 4n+3 = {-, color[2:0]}
  - Write on clock edge when `write_enable && writable && state==IDLE`. Writes while `busy` are dropped. Other addresses are ignored. Memories are not reset.
- FSM states IDLE, EVAL, FETCH.
  - IDLE → EVAL on `line_start`: latch `next_y`; clear all slot valid bits, slot count, and `overflow`.
  - EVAL: one object per cycle, index 0 upward.
    - Hit test uses 9-bit math: `obj_y <= next_y < obj_y+8`, no wrap. obj_y=0xFC covers 0xFC–0xFF only.
    - Each hit records the index into the next free slot.
    - A hit with all slots full sets `overflow` and ends EVAL immediately.
    - EVAL also ends after index `NUM_OBJECTS-1`.
  - FETCH: one slot per cycle, in ascending slot order.
    - Compute row = `next_y - obj_y` (3 bits); use 7-row if vflip.
    - Latch into the slot: the 16-bit PMF row, x, hflip, color, valid=1.
    - After the last occupied slot → IDLE. If there are zero hits, FETCH takes 0 cycles.
  - `line_start` in EVAL/FETCH restarts EVAL for the new `next_y`; the partial slot state is discarded.
- Compositing (IDLE only; valid=0 while busy):
  - Slot s covers `obj_x <= current_x < obj_x+8` in 9-bit math.
  - px = `current_x - obj_x`; use 7-px if hflip. Pixel = row bits [15-2px -: 2].
  - A pixel of 0 is transparent.
  - The lowest-index covering, opaque slot wins; this equals the lowest object index.
  - r = pix&{2{color[2]}}, g = pix&{2{color[1]}}, b = pix&{2{color[0]}}.
  - With no winner, rgb=0 and valid=0.

## Timing
- Reset: state IDLE, all slots invalid, `r=g=b=0`, `valid=0`, `overflow=0`, `busy=0`.
- Reset mid-EVAL/FETCH returns to IDLE with empty slots.
- `busy`=1 from the cycle after `line_start` until FETCH completes. Worst case `NUM_OBJECTS + MAX_PER_LINE` cycles (72 at defaults).
- Video timing guarantees that `line_start` leads the first active pixel by at least this worst case.
- Pixel outputs are registered: 1-cycle latency. Outputs for `current_x`=X appear the cycle after X is presented.
- `overflow` updates during EVAL, holds until the next `line_start`, and is registered with the pixel outputs.
- OBM/PMF contents are read at EVAL/FETCH time. Later writes do not alter the slots until the next line.

## Test plan
- Object 0 is x=10, y=20, pmfa=1, color=3'b100, and PMF row 0 of pattern 1 = 0xC000.
  - Stimulus: `line_start`, next_y=20, then sweep x.
  - Required: at x=10, one cycle late, r=2'b11, g=b=0, valid=1; x=11..17 valid=0.
- Objects 2 and 5 overlap at x=40 with opaque pixels. Required: the colour of object 2 is output.
- Hflip+vflip, next_y=27. Required: the output comes from pattern row 0, bit order reversed (leftmost pixel taken from bits [1:0]).
- 9 objects on y=50, MAX_PER_LINE=8. Required: `overflow`=1; objects 0–7 are drawn and the 9th is not. The next `line_start` with next_y=60 clears `overflow`.
- Object at y=0xFC, next_y=0x00. Required: no hit (no wrap). Object at x=0xFC: drawn at x=0xFC..0xFF only.
- Write to OBM while `busy`: dropped. Assert `rst` during EVAL: `busy`=0, valid=0, and slots are empty on the next line.
